// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI chip-select transaction controller.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRANSFER,
        CS_INACTIVE
    } state_t;

    localparam int SPI_BYTE_W = 8;

    // Width needed to hold a byte count of 0..max_bytes.
    function automatic int calc_cw(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

endpackage

// File: rtl/spi_cs_txn_ctrl.sv
// Chip-select transaction controller in front of a byte-level SPI master.
// Optional inter-byte timeout abort is enabled by defining SPI_CS_TXN_TIMEOUT_EN.
module spi_cs_txn_ctrl
    import spi_pkg::*;
#(
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int CS_INACTIVE_CLKS = 1,
    parameter int TIMEOUT_CLKS     = 64,
    localparam int CW              = calc_cw(MAX_BYTES_PER_CS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CW-1:0]         i_TX_Count,
    input  logic [SPI_BYTE_W-1:0] i_TX_Byte,
    input  logic                  i_TX_DV,
    output logic                  o_TX_Ready,
    output logic [CW-1:0]         o_RX_Count,
    output logic                  o_RX_DV,
    output logic [SPI_BYTE_W-1:0] o_RX_Byte,
    output logic                  o_Abort,
    output logic [SPI_BYTE_W-1:0] o_MOSI_Byte,
    output logic                  o_MOSI_DV,
    input  logic                  i_MOSI_Ready,
    input  logic                  i_MISO_DV,
    input  logic [SPI_BYTE_W-1:0] i_MISO_Byte,
    output logic                  o_CS_n
);

    localparam int GW = $clog2(CS_INACTIVE_CLKS + 1);

    state_t                  state;
    state_t                  state_next;
    logic [CW-1:0]           remaining;
    logic [CW-1:0]           rx_count;
    logic                    in_flight;
    logic [SPI_BYTE_W-1:0]   mosi_byte;
    logic [SPI_BYTE_W-1:0]   rx_byte;
    logic                    mosi_dv;
    logic                    rx_dv;
    logic [GW-1:0]           gap_cnt;

    logic                    tx_ready;
    logic                    cs_n;
    logic                    count_ok;
    logic                    tx_accept;
    logic                    start;
    logic                    forward;
    logic                    rx_take;
    logic                    gap_done;
    logic                    timeout_hit;

    assign count_ok  = (i_TX_Count != '0) && (i_TX_Count <= CW'(MAX_BYTES_PER_CS));
    assign tx_accept = i_TX_DV && tx_ready;
    assign start     = (state == IDLE) && tx_accept && count_ok;
    assign forward   = tx_accept && ((state == TRANSFER) || count_ok);
    assign rx_take   = (state == TRANSFER) && in_flight && i_MISO_DV;
    assign gap_done  = (gap_cnt == GW'(CS_INACTIVE_CLKS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = TRANSFER;
            end
            TRANSFER: begin
                if (timeout_hit || (remaining == '0 && !in_flight && i_MOSI_Ready))
                    state_next = CS_INACTIVE;
            end
            CS_INACTIVE: begin
                if (gap_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Ready is held low while reset is asserted so every output reads idle.
    always_comb begin
        tx_ready = 1'b0;
        cs_n     = 1'b1;
        case (state)
            IDLE: begin
                tx_ready = i_MOSI_Ready;
            end
            TRANSFER: begin
                cs_n     = 1'b0;
                tx_ready = !in_flight && (remaining != '0) && i_MOSI_Ready;
            end
            default: begin
                tx_ready = 1'b0;
            end
        endcase
        if (!rst) tx_ready = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining <= '0;
            rx_count  <= '0;
            in_flight <= 1'b0;
            mosi_byte <= '0;
            mosi_dv   <= 1'b0;
            rx_byte   <= '0;
            rx_dv     <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            mosi_dv <= 1'b0;
            rx_dv   <= 1'b0;
            if (forward) begin
                mosi_byte <= i_TX_Byte;
                mosi_dv   <= 1'b1;
                in_flight <= 1'b1;
            end
            if (start) begin
                remaining <= i_TX_Count;
                rx_count  <= '0;
            end
            if (rx_take) begin
                rx_byte   <= i_MISO_Byte;
                rx_dv     <= 1'b1;
                in_flight <= 1'b0;
                if (remaining != '0) remaining <= remaining - CW'(1);
                if (rx_count < CW'(MAX_BYTES_PER_CS)) rx_count <= rx_count + CW'(1);
            end
            if (timeout_hit) remaining <= '0;
            if (state == CS_INACTIVE) gap_cnt <= gap_cnt + GW'(1);
            else                      gap_cnt <= '0;
        end
    end

`ifdef SPI_CS_TXN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    logic [TW-1:0] to_cnt;
    logic          abort;

    assign timeout_hit = (state == TRANSFER) && tx_ready && !i_TX_DV &&
                         (to_cnt == TW'(TIMEOUT_CLKS - 1));

    // Counts only cycles where the controller could take a byte but none arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            abort  <= 1'b0;
        end else begin
            abort <= timeout_hit;
            if (state != TRANSFER || tx_accept || timeout_hit) begin
                to_cnt <= '0;
            end else if (tx_ready) begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    assign o_Abort = abort;
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CLKS;
    assign o_Abort            = 1'b0;
`endif

    assign o_TX_Ready  = tx_ready;
    assign o_CS_n      = cs_n;
    assign o_MOSI_Byte = mosi_byte;
    assign o_MOSI_DV   = mosi_dv;
    assign o_RX_Byte   = rx_byte;
    assign o_RX_DV     = rx_dv;
    assign o_RX_Count  = rx_count;

endmodule

// File: tb/tb_spi_cs_txn_ctrl.sv
// Self-checking bench for spi_cs_txn_ctrl with a behavioural byte-level SPI master.
// Build with SPI_CS_TXN_TIMEOUT_EN defined to exercise the timeout abort path.
module tb_spi_cs_txn_ctrl;

    localparam int MAX_BYTES = 2;
    localparam int GAP_CLKS  = 1;
    localparam int TO_CLKS   = 64;
    localparam int M_LAT     = 10;
`ifdef SPI_CS_TXN_TIMEOUT_EN
    localparam int EXP_ABORTS = 1;
`else
    localparam int EXP_ABORTS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] tx_count = '0;
    logic [7:0] tx_byte = '0;
    logic       tx_dv = 1'b0;
    logic       tx_ready;
    logic [1:0] rx_count;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       abort;
    logic [7:0] mosi_byte;
    logic       mosi_dv;
    logic       mosi_ready;
    logic       miso_dv;
    logic [7:0] miso_byte;
    logic       cs_n;

    int total = 0;
    int bad   = 0;

    spi_cs_txn_ctrl #(
        .MAX_BYTES_PER_CS(MAX_BYTES),
        .CS_INACTIVE_CLKS(GAP_CLKS),
        .TIMEOUT_CLKS    (TO_CLKS)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .i_TX_Count  (tx_count),
        .i_TX_Byte   (tx_byte),
        .i_TX_DV     (tx_dv),
        .o_TX_Ready  (tx_ready),
        .o_RX_Count  (rx_count),
        .o_RX_DV     (rx_dv),
        .o_RX_Byte   (rx_byte),
        .o_Abort     (abort),
        .o_MOSI_Byte (mosi_byte),
        .o_MOSI_DV   (mosi_dv),
        .i_MOSI_Ready(mosi_ready),
        .i_MISO_DV   (miso_dv),
        .i_MISO_Byte (miso_byte),
        .o_CS_n      (cs_n)
    );

    always #5 clk = ~clk;

    // Behavioural SPI master: busy for a fixed latency per byte, ready returns two cycles after MISO.
    bit         loopback = 1'b1;
    logic       m_busy;
    int         m_cnt;
    logic [7:0] m_byte;
    logic [7:0] m_resp;
    logic [7:0] resp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_ready <= 1'b1;
            miso_dv    <= 1'b0;
            miso_byte  <= '0;
            m_busy     <= 1'b0;
            m_cnt      <= 0;
            m_byte     <= '0;
        end else begin
            miso_dv <= 1'b0;
            if (!m_busy && mosi_dv) begin
                m_busy     <= 1'b1;
                mosi_ready <= 1'b0;
                m_cnt      <= 0;
                m_byte     <= mosi_byte;
            end else if (m_busy) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == M_LAT) begin
                    m_resp = loopback ? m_byte : 8'($urandom);
                    resp_q.push_back(m_resp);
                    miso_dv   <= 1'b1;
                    miso_byte <= m_resp;
                end
                if (m_cnt == M_LAT + 2) begin
                    m_busy     <= 1'b0;
                    mosi_ready <= 1'b1;
                end
            end
        end
    end

    logic [7:0] mosi_q[$];
    logic [7:0] rxb_q[$];
    logic [1:0] rxc_q[$];
    int         cs_rise = 0;
    int         cs_low_cycles = 0;
    int         cs_sync_bad = 0;
    int         abort_cnt = 0;
    logic       cs_prev = 1'b1;

    // Event recorder: CS must fall exactly on the first MOSI_DV cycle.
    always @(negedge clk) begin
        if (mosi_dv) mosi_q.push_back(mosi_byte);
        if (rx_dv) begin
            rxb_q.push_back(rx_byte);
            rxc_q.push_back(rx_count);
        end
        if (mosi_dv && cs_n) cs_sync_bad++;
        if (!cs_n && cs_prev && !mosi_dv) cs_sync_bad++;
        if (cs_n && !cs_prev) cs_rise++;
        if (!cs_n) cs_low_cycles++;
        if (abort) abort_cnt++;
        cs_prev = cs_n;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_output("ready_wait", 32'(tx_ready), 32'd1);
    endtask

    task automatic apply_stimulus(input logic [1:0] cnt, input logic [7:0] b);
        wait_ready();
        tx_dv    = 1'b1;
        tx_byte  = b;
        tx_count = cnt;
        @(negedge clk);
        tx_dv    = 1'b0;
        tx_count = 2'($urandom_range(0, 3));
    endtask

    task automatic clear_logs();
        mosi_q.delete();
        rxb_q.delete();
        rxc_q.delete();
        resp_q.delete();
    endtask

    task automatic finish_txn(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input int rise_mark);
        int k = 0;
        int g = 0;
        logic [7:0] exp_b;
        while (!cs_n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check_output("cs_release", 32'(cs_n), 32'd1);
        while (!tx_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check_output("cs_gap", 32'(g), 32'(GAP_CLKS));
        @(negedge clk);
        check_output("mosi_count", 32'(mosi_q.size()), 32'(n));
        check_output("rx_count_n", 32'(rxb_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            exp_b = (i == 0) ? b0 : b1;
            if (i < mosi_q.size()) check_output("mosi_byte", 32'(mosi_q[i]), 32'(exp_b));
            if (i < rxb_q.size()) begin
                if (!loopback && i < resp_q.size()) exp_b = resp_q[i];
                check_output("rx_byte", 32'(rxb_q[i]), 32'(exp_b));
                check_output("rx_index", 32'(rxc_q[i]), 32'(i + 1));
            end
        end
        check_output("cs_rises", 32'(cs_rise - rise_mark), 32'd1);
        check_output("rx_count_hold", 32'(rx_count), 32'(n));
        check_output("cs_sync", 32'(cs_sync_bad), 32'd0);
        clear_logs();
    endtask

    task automatic run_txn(input int n, input logic [7:0] b0, input logic [7:0] b1);
        int rise_mark;
        wait_ready();
        rise_mark = cs_rise;
        apply_stimulus(2'(n), b0);
        if (n > 1) apply_stimulus(2'($urandom_range(0, 3)), b1);
        finish_txn(n, b0, b1, rise_mark);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int low_mark;
        int rise_mark;
        int t;
        logic [7:0] r0;
        logic [7:0] r1;

        repeat (3) @(negedge clk);
        check_output("rst_cs_n",      32'(cs_n),      32'd1);
        check_output("rst_tx_ready",  32'(tx_ready),  32'd0);
        check_output("rst_mosi_dv",   32'(mosi_dv),   32'd0);
        check_output("rst_rx_count",  32'(rx_count),  32'd0);
        check_output("rst_abort",     32'(abort),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("idle_ready", 32'(tx_ready), 32'd1);

        loopback = 1'b1;
        run_txn(1, 8'h37, 8'h00);
        run_txn(2, 8'h38, 8'h39);
        run_txn(1, 8'hA5, 8'h00);
        run_txn(1, 8'h5A, 8'h00);

        // Out-of-range counts must be dropped with CS left high.
        wait_ready();
        low_mark = cs_low_cycles;
        tx_dv = 1'b1; tx_byte = 8'hEE; tx_count = 2'd0;
        @(negedge clk);
        tx_count = 2'd3;
        @(negedge clk);
        tx_dv = 1'b0;
        repeat (4) @(negedge clk);
        check_output("illegal_mosi", 32'(mosi_q.size()), 32'd0);
        check_output("illegal_cs",   32'(cs_low_cycles - low_mark), 32'd0);
        check_output("illegal_ready", 32'(tx_ready), 32'd1);

        apply_stimulus(2'd1, 8'hC3);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("midrst_cs_n",   32'(cs_n),      32'd1);
        check_output("midrst_ready",  32'(tx_ready),  32'd0);
        check_output("midrst_mosi",   32'({mosi_dv, mosi_byte}), 32'd0);
        check_output("midrst_rx",     32'({rx_dv, rx_byte, rx_count}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_logs();
        cs_sync_bad = 0;
        run_txn(1, 8'h11, 8'h00);

        loopback = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            run_txn($urandom_range(1, MAX_BYTES), r0, r1);
        end

        // Withhold the second byte of a two-byte transaction.
        wait_ready();
        rise_mark = cs_rise;
        r0 = 8'($urandom);
        r1 = 8'($urandom);
        apply_stimulus(2'd2, r0);
        wait_ready();
`ifdef SPI_CS_TXN_TIMEOUT_EN
        t = 0;
        while (!abort && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_output("abort_delay", 32'(t), 32'(TO_CLKS));
        check_output("abort_cs_n", 32'(cs_n), 32'd1);
        finish_txn(1, r0, r1, rise_mark);
`else
        t = 0;
        repeat (100) begin
            @(negedge clk);
            t++;
        end
        check_output("hold_cs_low", 32'(cs_n), 32'd0);
        check_output("hold_ready", 32'(tx_ready), 32'd1);
        check_output("hold_no_abort", 32'(abort_cnt), 32'd0);
        apply_stimulus(2'($urandom_range(0, 3)), r1);
        finish_txn(2, r0, r1, rise_mark);
`endif

        check_output("abort_total", 32'(abort_cnt), 32'(EXP_ABORTS));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_cs_txn_ctrl.md
Name: spi_cs_txn_ctrl

Overview:
- Transaction-level front end for the byte-level SPI master. Sits directly upstream of the master's byte handshake.
- Owns the active-low chip select.
- Groups 1..MAX_BYTES_PER_CS bytes into one CS-low transaction, forwards each user byte to the master, and returns received bytes with a per-transaction index.
- Enforces a minimum CS-high gap between transactions.

Parameters:
- MAX_BYTES_PER_CS, 2, maximum bytes per CS-low transaction (>=1).
- CS_INACTIVE_CLKS, 1, clk cycles CS_n held high after a transaction before the next may start (>=1).
- TIMEOUT_CLKS, 64, idle cycles allowed between bytes inside a transaction (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i_TX_Count  in  CW  bytes in transaction, sampled at the start byte only; CW = $clog2(MAX_BYTES_PER_CS+1).
- i_TX_Byte  in  8  byte to send.
- i_TX_DV  in  1  one-cycle valid for i_TX_Byte.
- o_TX_Ready  out  1  controller accepts i_TX_DV this cycle.
- o_RX_Count  out  CW  index+1 of last received byte in current transaction.
- o_RX_DV  out  1  one-cycle valid for o_RX_Byte.
- o_RX_Byte  out  8  received byte.
- o_Abort  out  1  one-cycle pulse on timeout abort (tied 0 without the optional feature).
- o_MOSI_Byte  out  8  byte to SPI master.
- o_MOSI_DV  out  1  one-cycle valid to SPI master.
- i_MOSI_Ready  in  1  SPI master idle/ready.
- i_MISO_DV  in  1  SPI master received-byte valid.
- i_MISO_Byte  in  8  SPI master received byte.
- o_CS_n  out  1  chip select, active low.

Behaviour:
- Reset (rst=0, async): state IDLE, o_CS_n=1, o_TX_Ready=0, o_MOSI_DV=0, o_MOSI_Byte=0, o_RX_DV=0, o_RX_Byte=0, o_RX_Count=0, o_Abort=0, remaining count=0.
  - Mid-transfer reset forces CS_n high immediately; the in-flight byte is discarded.
- FSM states:
  - IDLE: o_TX_Ready = i_MOSI_Ready.
    - i_TX_DV=1 with i_TX_Count in 1..MAX_BYTES_PER_CS: latch remaining = i_TX_Count, go to TRANSFER.
    - i_TX_Count=0 or >MAX_BYTES_PER_CS: request dropped, stay IDLE, CS unchanged.
  - TRANSFER: CS_n=0.
    - The byte accepted at edge N appears as o_MOSI_Byte with o_MOSI_DV=1 for exactly one cycle at N+1. o_CS_n falls at N+1, the same cycle.
    - o_TX_Ready=0 while a byte is in flight.
    - On i_MISO_DV: o_RX_Byte<=i_MISO_Byte, o_RX_DV pulse next cycle, o_RX_Count increments, remaining decrements.
    - If remaining>0 after decrement: o_TX_Ready = i_MOSI_Ready; next i_TX_DV is forwarded with the same 1-cycle latency, and i_TX_Count is ignored.
    - If remaining=0: wait for i_MOSI_Ready=1, then go to CS_INACTIVE.
  - CS_INACTIVE: o_CS_n=1, o_TX_Ready=0 for exactly CS_INACTIVE_CLKS cycles, then IDLE.
- o_RX_Count clears to 0 on the cycle CS_n falls. It holds its value after the transaction until then.
- i_TX_DV while o_TX_Ready=0 is ignored; there is no queueing.
- i_MISO_DV outside TRANSFER is ignored.
- Counters are unsigned CW bits and never wrap: remaining is never decremented below 0.

Optional Feature:
- Macro: SPI_CS_TXN_TIMEOUT_EN.
- Defined: in TRANSFER with remaining>0 and o_TX_Ready=1, a counter increments each cycle without i_TX_DV.
  - On reaching TIMEOUT_CLKS: o_Abort pulses one cycle, remaining<=0, go to CS_INACTIVE.
  - The counter clears on each accepted byte.
- Undefined: no counter; the controller waits indefinitely; o_Abort tied 0.

Decomposition:
- Package spi_pkg:
  - state enum (IDLE, TRANSFER, CS_INACTIVE);
  - byte width constant SPI_BYTE_W=8;
  - function returning CW for a given MAX_BYTES_PER_CS.
- No sub-module: FSM plus two small counters fit in one module. The SPI master is instantiated beside it by the parent, not inside.

Test Plan:
- Single byte, loopback master (MISO tied MOSI), mode 3, CLKS_PER_HALF_BIT=4: i_TX_Count=1, byte 0x37 -> CS_n low one cycle after DV; o_RX_DV with 0xAB? no: o_RX_Byte=0x37, o_RX_Count=1; CS_n high for exactly 1 clk, then o_TX_Ready=1.
- Two-byte transaction: Count=2, bytes 0x38 then 0x39 -> CS_n stays low across both; RX 0x38 (count 1), 0x39 (count 2); a single CS_n rising edge.
- Back-to-back transactions: Count=1 0xA5, then immediate Count=1 0x5A -> CS_n high gap = CS_INACTIVE_CLKS; o_RX_Count restarts at 1.
- Illegal counts: i_TX_Count=0 and i_TX_Count=3 with DV -> no o_MOSI_DV, CS_n stays 1, o_TX_Ready remains 1.
- Reset mid-transfer: drop rst during byte 0xC3 -> o_CS_n=1 and all outputs 0 asynchronously; after release, Count=1 0x11 returns 0x11.
- With SPI_CS_TXN_TIMEOUT_EN, TIMEOUT_CLKS=64: Count=2, send 0x22, withhold second byte -> o_Abort pulse 64 cycles after o_TX_Ready re-asserts; CS_n rises; IDLE after gap.
